// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// (IF) and data-memory (DM) requesters over a registered req/ack handshake.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects alternating priority;
// when undefined, DM has fixed priority and a starve counter protects IF.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_ready,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [ADDR_WIDTH-1:0]     dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    input  logic [DATA_WIDTH/8-1:0]   dm_be,
    output logic                      dm_ready,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } state_t;

    state_t state;
    logic   arb_ok;
    logic   pick_if;
    logic   grant_if;
    logic   grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_dm;  // 0: IF preferred on a tie, 1: DM preferred on a tie
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt;
`endif

    // Arbitration: only in IDLE and never during a ready-pulse cycle, so a
    // requester holding req across its ready pulse is not re-served early.
    always_comb begin
        arb_ok = (state == IDLE) && !if_ready && !dm_ready;
`ifdef ARB_ROUND_ROBIN_EN
        pick_if = if_req && (!dm_req || !rr_dm);
`else
        pick_if = if_req && (!dm_req || (starve_cnt >= LIMIT));
`endif
        grant_if = arb_ok && pick_if;
        grant_dm = arb_ok && dm_req && !pick_if;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer: after each grant, prefer the other port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_dm <= 1'b0;
        end else if (grant_if) begin
            rr_dm <= 1'b1;
        end else if (grant_dm) begin
            rr_dm <= 1'b0;
        end
    end
`else
    // Starve counter: counts DM wins while IF waits, saturating at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`endif

    // Handshake FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state     <= GNT_IF;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end else if (grant_dm) begin
                        state     <= GNT_DM;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                    end
                end
                GNT_IF: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                GNT_DM: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        dm_ready <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default fixed-priority
// build; the simultaneous-request ordering also covers ARB_ROUND_ROBIN_EN).
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_ready (dm_ready),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        dm_first;
        logic [31:0] first_addr;
        logic [31:0] second_addr;

        // Reset state
        tick();
        tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_readies", {30'd0, if_ready, dm_ready}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", if_rdata | dm_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // 1: IF fetch, ack in the first mem_req cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        tick();
        check("t1_mem_req", {31'd0, mem_req}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_mem_we", {31'd0, mem_we}, 32'd0);
        check("t1_mem_be", {28'd0, mem_be}, 32'hF);
        check("t1_mem_addr", mem_addr, 32'h0000_0040);
        check("t1_if_ready_early", {31'd0, if_ready}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2402_000A;
        tick();
        check("t1_if_ready", {31'd0, if_ready}, 32'd1);
        check("t1_if_rdata", if_rdata, 32'h2402_000A);
        check("t1_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("t1_busy_drop", {31'd0, busy}, 32'd0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();
        check("t1_if_ready_pulse", {31'd0, if_ready}, 32'd0);
        check("t1_if_rdata_hold", if_rdata, 32'h2402_000A);

        // 2: DM write with a 3-cycle ack delay
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0100;
        dm_wdata = 32'h1234_5678;
        dm_be    = 4'b0011;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("t2_mem_req", {31'd0, mem_req}, 32'd1);
            check("t2_mem_we", {31'd0, mem_we}, 32'd1);
            check("t2_mem_addr", mem_addr, 32'h0000_0100);
            check("t2_mem_wdata", mem_wdata, 32'h1234_5678);
            check("t2_mem_be", {28'd0, mem_be}, 32'h3);
            check("t2_dm_ready_early", {31'd0, dm_ready}, 32'd0);
            tick();
        end
        check("t2_mem_addr_3rd", mem_addr, 32'h0000_0100);
        check("t2_mem_req_3rd", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("t2_dm_ready", {31'd0, dm_ready}, 32'd1);
        check("t2_dm_rdata_unchanged", dm_rdata, 32'd0);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        tick();
        check("t2_dm_ready_pulse", {31'd0, dm_ready}, 32'd0);

        // 6: stray ack in IDLE
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check("t6_readies", {30'd0, if_ready, dm_ready}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_mem_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        tick();
        check("t6_rdata_hold", if_rdata, 32'h2402_000A);

        // 3: simultaneous IF and DM requests
`ifdef ARB_ROUND_ROBIN_EN
        dm_first = 1'b0;
`else
        dm_first = 1'b1;
`endif
        first_addr  = dm_first ? 32'h0000_0200 : 32'h0000_0080;
        second_addr = dm_first ? 32'h0000_0080 : 32'h0000_0200;
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0200;
        dm_be   = 4'hF;
        tick();
        check("t3_first_addr", mem_addr, first_addr);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        check("t3_first_ready", {30'd0, if_ready, dm_ready}, dm_first ? 32'd1 : 32'd2);
        check("t3_first_rdata", dm_first ? dm_rdata : if_rdata, 32'h1111_2222);
        mem_ack = 1'b0;
        if (dm_first) dm_req = 1'b0;
        else if_req = 1'b0;
        tick();
        check("t3_ready_cycle_idle", {31'd0, mem_req}, 32'd0);
        tick();
        check("t3_second_addr", mem_addr, second_addr);
        check("t3_second_busy", {31'd0, busy}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        check("t3_second_ready", {30'd0, if_ready, dm_ready}, dm_first ? 32'd2 : 32'd1);
        check("t3_second_rdata", dm_first ? if_rdata : dm_rdata, 32'h3333_4444);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        tick();

`ifndef ARB_ROUND_ROBIN_EN
        // 4: IF starved by continuous DM requests until 8 DM grants
        if_req  = 1'b1;
        if_addr = 32'h0000_0084;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0300;
        for (int g = 0; g < 8; g++) begin
            tick();
            check("t4_dm_grant", mem_addr, 32'h0000_0300);
            mem_ack   = 1'b1;
            mem_rdata = 32'h0000_1000 + 32'(g);
            tick();
            mem_ack = 1'b0;
            check("t4_dm_ready", {30'd0, if_ready, dm_ready}, 32'd1);
            tick();
            check("t4_ready_cycle_idle", {31'd0, mem_req}, 32'd0);
        end
        tick();
        check("t4_if_forced", mem_addr, 32'h0000_0084);
        check("t4_if_forced_we", {31'd0, mem_we}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_6666;
        tick();
        check("t4_if_ready", {30'd0, if_ready, dm_ready}, 32'd2);
        check("t4_if_rdata", if_rdata, 32'h5555_6666);
        check("t4_dm_rdata_last", dm_rdata, 32'h0000_1007);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        tick();
        tick();
`endif

        // 5: reset during GNT_DM, late ack ignored
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0400;
        dm_wdata = 32'hAAAA_5555;
        tick();
        check("t5_granted", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_mem_req", {31'd0, mem_req}, 32'd0);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b1;
        tick();
        check("t5_late_ack_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        check("t5_late_ack_busy", {31'd0, busy}, 32'd0);
        mem_ack = 1'b0;
        tick();
        check("t5_no_ready_after", {31'd0, dm_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
